spi_host_multi: RTL and testbench

- Parametrised successor to the single-card DivMMC SPI logic: a port-mapped SPI mode-0 host serving NUM_CS devices (SD cards, flash, etc.).
- Adds a programmable SCK divider, a separate receive buffer, edge-triggered access detection, a status/overrun register and optional CPU wait-stall.
- Sits beside the CPU bus decoder. Its d_out/d_out_active feed the top-level read mux.

---
 rtl/spi_host_multi.sv | 164 ++++++++++++++++
 tb/tb_spi_host_multi.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_multi.sv
// Port-mapped SPI mode-0 host for NUM_CS devices with programmable SCK divider,
// status/overrun register and optional CPU wait-stall (macro SPI_HOST_MULTI_WAIT_EN).
module spi_host_multi #(
  parameter logic [7:0] DATA_PORT = 8'hEB,
  parameter logic [7:0] CTRL_PORT = 8'hE7,
  parameter int         NUM_CS    = 2,
  parameter int         DIV_W     = 4,
  parameter int         DIV_RST   = 0
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        a,
  input  logic [7:0]        d_in,
  input  logic              ioreq,
  input  logic              rd,
  input  logic              wr,
  output logic [7:0]        d_out,
  output logic              d_out_active,
  output logic              busy,
  output logic              wait_out,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  state_t              state, state_next;
  logic                load;
  logic                phase_end;
  logic [DIV_W-1:0]    div, cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          tx_sh, rx_sh, rx_buf, status;
  logic [NUM_CS-1:0]   cs_n;
  logic                overrun;
  logic                data_cs, ctrl_cs;
  logic                data_rd_lvl, data_wr_lvl, ctrl_rd_lvl, ctrl_wr_lvl;
  logic                data_rd_q, data_wr_q, ctrl_rd_q, ctrl_wr_q;
  logic                data_rd_stb, data_wr_stb, ctrl_rd_stb, ctrl_wr_stb;
  logic                data_stb, start, data_gate;

  assign data_cs     = en & ioreq & (a == DATA_PORT);
  assign ctrl_cs     = en & ioreq & (a == CTRL_PORT);
  assign data_rd_lvl = data_cs & rd;
  assign data_wr_lvl = data_cs & wr;
  assign ctrl_rd_lvl = ctrl_cs & rd;
  assign ctrl_wr_lvl = ctrl_cs & wr;

`ifdef SPI_HOST_MULTI_WAIT_EN
  // While busy the data level is hidden from the edge detector, so a held
  // access re-appears as a fresh edge on the first idle cycle after DONE.
  assign data_gate = ~busy;
  assign wait_out  = (data_rd_lvl | data_wr_lvl) & busy;
`else
  assign data_gate = 1'b1;
  assign wait_out  = 1'b0;
`endif

  assign data_rd_stb = data_rd_lvl & ~data_rd_q & data_gate;
  assign data_wr_stb = data_wr_lvl & ~data_wr_q & data_gate;
  assign ctrl_rd_stb = ctrl_rd_lvl & ~ctrl_rd_q;
  assign ctrl_wr_stb = ctrl_wr_lvl & ~ctrl_wr_q;
  assign data_stb    = data_rd_stb | data_wr_stb;
  assign start       = data_stb & (state == S_IDLE);

  assign busy      = (state != S_IDLE);
  assign phase_end = (cnt == '0);
  assign spi_sck   = (state == S_HIGH);
  assign spi_mosi  = (state == S_LOW || state == S_HIGH) ? tx_sh[7] : 1'b1;
  assign spi_cs_n  = cs_n;
  assign state_dbg = state;

  always_comb begin
    status = {busy, overrun, 6'b0};
    status[NUM_CS-1:0] = cs_n;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_LOW;
        load       = 1'b1;
      end
      S_LOW: if (phase_end) begin
        state_next = S_HIGH;
        load       = 1'b1;
      end
      S_HIGH: if (phase_end) begin
        state_next = (bit_cnt == 3'd7) ? S_DONE : S_LOW;
        load       = 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      data_rd_q    <= 1'b0;
      data_wr_q    <= 1'b0;
      ctrl_rd_q    <= 1'b0;
      ctrl_wr_q    <= 1'b0;
      d_out        <= 8'h00;
      d_out_active <= 1'b0;
      cs_n         <= '1;
      div          <= DIV_W'(DIV_RST);
      cnt          <= '0;
      bit_cnt      <= 3'd0;
      tx_sh        <= 8'hFF;
      rx_sh        <= 8'hFF;
      rx_buf       <= 8'hFF;
      overrun      <= 1'b0;
    end else begin
      data_rd_q    <= data_rd_lvl & data_gate;
      data_wr_q    <= data_wr_lvl & data_gate;
      ctrl_rd_q    <= ctrl_rd_lvl;
      ctrl_wr_q    <= ctrl_wr_lvl;
      d_out_active <= (data_cs | ctrl_cs) & rd;

      // Read data is captured at the strobe, so a status read shows overrun
      // before its own clear takes effect.
      if (ctrl_rd_stb)      d_out <= status;
      else if (data_rd_stb) d_out <= rx_buf;

      if (ctrl_wr_stb) begin
        if (d_in[7]) div  <= d_in[DIV_W-1:0];
        else         cs_n <= d_in[NUM_CS-1:0];
      end

      if (ctrl_rd_stb)     overrun <= 1'b0;
      if (data_stb & busy) overrun <= 1'b1;

      if (load)             cnt <= div;
      else if (!phase_end)  cnt <= cnt - CNT_ONE;

      if (start) begin
        tx_sh   <= data_wr_stb ? d_in : 8'hFF;
        bit_cnt <= 3'd0;
      end

      if (state == S_LOW && phase_end)
        rx_sh <= {rx_sh[6:0], spi_miso};

      if (state == S_HIGH && phase_end) begin
        tx_sh   <= {tx_sh[6:0], 1'b1};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) rx_buf <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_multi.sv
// Self-checking bench for spi_host_multi: randomized transfers compared against
// a byte-level model of the SPI exchange, status register and timing.
module tb_spi_host_multi;

  localparam logic [7:0] DATA = 8'hEB;
  localparam logic [7:0] CTRL = 8'hE7;

  logic       clk28 = 1'b0;
  logic       rst_n, en, ioreq, rd, wr, spi_miso;
  logic [7:0] a, d_in;
  logic [7:0] d_out;
  logic       d_out_active, busy, wait_out, spi_sck, spi_mosi;
  logic [1:0] spi_cs_n;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [1:0] m_cs;
  logic       m_ovr;
  logic [7:0] m_rx;
  logic [7:0] miso_pat = 8'hFF;

  // bus monitor
  int   busy_cnt = 0;
  int   cyc      = 0;
  int   rise_k   = 0;
  logic sck_prev = 1'b0;
  logic mosi_q[$];
  int   rise_t_q[$];

  spi_host_multi dut (
    .clk28(clk28), .rst_n(rst_n), .en(en), .a(a), .d_in(d_in),
    .ioreq(ioreq), .rd(rd), .wr(wr), .d_out(d_out), .d_out_active(d_out_active),
    .busy(busy), .wait_out(wait_out), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .state_dbg(state_dbg)
  );

  initial forever #5 clk28 = ~clk28;

  // Slave model: records MOSI on each SCK rise and presents miso_pat MSB first.
  always @(negedge clk28) begin
    if (busy) busy_cnt++;
    if (spi_sck && !sck_prev) begin
      mosi_q.push_back(spi_mosi);
      rise_t_q.push_back(cyc);
      rise_k++;
    end
    sck_prev = spi_sck;
    spi_miso = (rise_k < 8) ? miso_pat[7 - rise_k] : 1'b1;
    cyc++;
  end

  task automatic clear_mon();
    busy_cnt = 0;
    rise_k   = 0;
    mosi_q.delete();
    rise_t_q.delete();
  endtask

  function automatic logic [7:0] mosi_byte(input int off);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[7 - i] = (off + i < mosi_q.size()) ? mosi_q[off + i] : 1'bx;
    return v;
  endfunction

  function automatic int bad_gaps(input int per);
    int b = 0;
    for (int i = 1; i < rise_t_q.size(); i++)
      if (rise_t_q[i] - rise_t_q[i - 1] != per) b++;
    return b;
  endfunction

  function automatic logic [7:0] exp_status(input logic b);
    logic [7:0] s;
    s = {b, m_ovr, 6'b0};
    s[1:0] = m_cs;
    return s;
  endfunction

  task automatic io_write(input logic [7:0] port, input logic [7:0] val);
    @(posedge clk28); #1;
    a = port; d_in = val; ioreq = 1'b1; wr = 1'b1;
    @(posedge clk28); #1;
    ioreq = 1'b0; wr = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] val, output logic act);
    @(posedge clk28); #1;
    a = port; ioreq = 1'b1; rd = 1'b1;
    @(posedge clk28); #1;
    val = d_out; act = d_out_active;
    ioreq = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk28);
      if (!busy) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL %s_idle: busy=1 after %0d cycles, required 0", name, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [7:0] v; logic act;
    rst_n = 1'b0; en = 1'b1; ioreq = 1'b0; rd = 1'b0; wr = 1'b0;
    a = 8'h00; d_in = 8'h00; spi_miso = 1'b1;
    m_cs = 2'b11; m_ovr = 1'b0; m_rx = 8'hFF;
    repeat (3) @(posedge clk28);
    @(negedge clk28); rst_n = 1'b1;
    #1;
    n_checks++; if (d_out_active !== 1'b0) $display("FAIL rst_active: got %b, required 0", d_out_active); else n_pass++;
    n_checks++; if (spi_sck !== 1'b0) $display("FAIL rst_sck: got %b, required 0", spi_sck); else n_pass++;
    n_checks++; if (spi_mosi !== 1'b1) $display("FAIL rst_mosi: got %b, required 1", spi_mosi); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (spi_cs_n !== 2'b11) $display("FAIL rst_cs: got %b, required 11", spi_cs_n); else n_pass++;
    n_checks++; if (wait_out !== 1'b0) $display("FAIL rst_wait: got %b, required 0", wait_out); else n_pass++;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b0)) $display("FAIL rst_status: got %h, required %h", v, exp_status(1'b0)); else n_pass++;
    n_checks++; if (act !== 1'b1) $display("FAIL rst_read_active: got %b, required 1", act); else n_pass++;
    @(posedge clk28); #1;
    n_checks++; if (d_out_active !== 1'b0) $display("FAIL read_active_drop: got %b, required 0", d_out_active); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] v; logic act;
    io_write(CTRL, 8'h02); m_cs = 2'b10;
    n_checks++; if (spi_cs_n !== m_cs) $display("FAIL basic_cs: got %b, required %b", spi_cs_n, m_cs); else n_pass++;
    miso_pat = 8'hFF; clear_mon();
    io_write(DATA, 8'hA5);
    wait_idle("basic", 200);
    n_checks++; if (mosi_q.size() != 8) $display("FAIL basic_edges: got %0d, required 8", mosi_q.size()); else n_pass++;
    n_checks++; if (mosi_byte(0) !== 8'hA5) $display("FAIL basic_mosi: got %h, required a5", mosi_byte(0)); else n_pass++;
    n_checks++; if (busy_cnt != 17) $display("FAIL basic_busy_len: got %0d, required 17", busy_cnt); else n_pass++;
    n_checks++; if (bad_gaps(2) != 0) $display("FAIL basic_sck_period: got %0d bad gaps, required 0", bad_gaps(2)); else n_pass++;
    m_rx = miso_pat;
    miso_pat = 8'h5A; clear_mon();
    io_read(DATA, v, act);
    n_checks++; if (v !== m_rx) $display("FAIL basic_rx: got %h, required %h", v, m_rx); else n_pass++;
    wait_idle("basic_rd", 200);
    m_rx = miso_pat;
  endtask

  task automatic test_div();
    logic [7:0] v; logic act;
    io_write(CTRL, 8'h83);
    miso_pat = 8'h3C; clear_mon();
    io_write(DATA, 8'h00);
    wait_idle("div", 300);
    n_checks++; if (busy_cnt != 65) $display("FAIL div_busy_len: got %0d, required 65", busy_cnt); else n_pass++;
    n_checks++; if (bad_gaps(8) != 0) $display("FAIL div_sck_period: got %0d bad gaps, required 0", bad_gaps(8)); else n_pass++;
    n_checks++; if (mosi_byte(0) !== 8'h00) $display("FAIL div_mosi: got %h, required 00", mosi_byte(0)); else n_pass++;
    m_rx = miso_pat;
    miso_pat = 8'($urandom); clear_mon();
    io_read(DATA, v, act);
    n_checks++; if (v !== m_rx) $display("FAIL div_rx: got %h, required %h", v, m_rx); else n_pass++;
    wait_idle("div_rd", 300);
    n_checks++; if (mosi_byte(0) !== 8'hFF) $display("FAIL div_read_mosi: got %h, required ff", mosi_byte(0)); else n_pass++;
    n_checks++; if (busy_cnt != 65) $display("FAIL div_read_len: got %0d, required 65", busy_cnt); else n_pass++;
    m_rx = miso_pat;
    io_write(CTRL, 8'h80);
  endtask

  task automatic test_collision();
    logic [7:0] v; logic act; logic [7:0] p; logic ok;
    io_write(CTRL, 8'h03); m_cs = 2'b11;
    p = 8'($urandom); miso_pat = p; clear_mon();
    io_write(DATA, 8'h11);
`ifdef SPI_HOST_MULTI_WAIT_EN
    @(posedge clk28); #1;
    a = DATA; d_in = 8'h22; ioreq = 1'b1; wr = 1'b1;
    @(negedge clk28);
    n_checks++; if (wait_out !== 1'b1) $display("FAIL wait_assert: got %b, required 1", wait_out); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk28); #1;
      if (!wait_out) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL wait_release: got wait_out=1, required 0 within 100 cycles"); else n_pass++;
    @(posedge clk28); #1;
    ioreq = 1'b0; wr = 1'b0;
    wait_idle("wait", 200);
    n_checks++; if (mosi_byte(0) !== 8'h11) $display("FAIL wait_first: got %h, required 11", mosi_byte(0)); else n_pass++;
    n_checks++; if (mosi_byte(8) !== 8'h22) $display("FAIL wait_second: got %h, required 22", mosi_byte(8)); else n_pass++;
    m_rx = 8'hFF;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b0)) $display("FAIL wait_status: got %h, required %h", v, exp_status(1'b0)); else n_pass++;
`else
    io_write(DATA, 8'h22); m_ovr = 1'b1;
    n_checks++; if (wait_out !== 1'b0) $display("FAIL ovr_wait: got %b, required 0", wait_out); else n_pass++;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b1)) $display("FAIL ovr_status_busy: got %h, required %h", v, exp_status(1'b1)); else n_pass++;
    m_ovr = 1'b0;
    io_read(DATA, v, act); m_ovr = 1'b1;
    n_checks++; if (v !== m_rx) $display("FAIL ovr_busy_rx: got %h, required %h", v, m_rx); else n_pass++;
    wait_idle("ovr", 200);
    n_checks++; if (mosi_q.size() != 8) $display("FAIL ovr_edges: got %0d, required 8", mosi_q.size()); else n_pass++;
    n_checks++; if (mosi_byte(0) !== 8'h11) $display("FAIL ovr_mosi: got %h, required 11", mosi_byte(0)); else n_pass++;
    m_rx = p;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b0)) $display("FAIL ovr_status_idle: got %h, required %h", v, exp_status(1'b0)); else n_pass++;
    m_ovr = 1'b0;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b0)) $display("FAIL ovr_status_cleared: got %h, required %h", v, exp_status(1'b0)); else n_pass++;
    ok = 1'b1;
    ok = ok;
`endif
  endtask

  task automatic test_cs_mid();
    logic [7:0] tx;
    tx = 8'($urandom); miso_pat = 8'($urandom); clear_mon();
    io_write(DATA, tx);
    io_write(CTRL, 8'h01); m_cs = 2'b01;
    n_checks++; if (spi_cs_n !== m_cs) $display("FAIL csmid_cs: got %b, required %b", spi_cs_n, m_cs); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL csmid_busy: got %b, required 1", busy); else n_pass++;
    wait_idle("csmid", 200);
    n_checks++; if (busy_cnt != 17) $display("FAIL csmid_len: got %0d, required 17", busy_cnt); else n_pass++;
    n_checks++; if (mosi_byte(0) !== tx) $display("FAIL csmid_mosi: got %h, required %h", mosi_byte(0), tx); else n_pass++;
    m_rx = miso_pat;
    io_write(CTRL, 8'h03); m_cs = 2'b11;
  endtask

  task automatic test_random();
    logic [7:0] v, tx; logic act; int dv;
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 3);
      io_write(CTRL, 8'h80 | 8'(dv));
      tx = 8'($urandom); miso_pat = 8'($urandom); clear_mon();
      io_write(DATA, tx);
      wait_idle("rand", 300);
      n_checks++; if (mosi_byte(0) !== tx) $display("FAIL rand_mosi: got %h, required %h", mosi_byte(0), tx); else n_pass++;
      n_checks++; if (busy_cnt != 16 * (dv + 1) + 1) $display("FAIL rand_len: got %0d, required %0d", busy_cnt, 16 * (dv + 1) + 1); else n_pass++;
      n_checks++; if (bad_gaps(2 * (dv + 1)) != 0) $display("FAIL rand_period: got %0d bad gaps, required 0", bad_gaps(2 * (dv + 1))); else n_pass++;
      m_rx = miso_pat;
      miso_pat = 8'($urandom); clear_mon();
      io_read(DATA, v, act);
      n_checks++; if (v !== m_rx) $display("FAIL rand_rx: got %h, required %h", v, m_rx); else n_pass++;
      wait_idle("rand_rd", 300);
      m_rx = miso_pat;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v; logic act; logic ok;
    io_write(CTRL, 8'h83);
    miso_pat = 8'h00; clear_mon();
    io_write(DATA, 8'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk28);
      if (rise_k >= 4) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL rstmid_reach: got %0d edges, required 4", rise_k); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (spi_sck !== 1'b0) $display("FAIL rstmid_sck: got %b, required 0", spi_sck); else n_pass++;
    n_checks++; if (spi_mosi !== 1'b1) $display("FAIL rstmid_mosi: got %b, required 1", spi_mosi); else n_pass++;
    n_checks++; if (spi_cs_n !== 2'b11) $display("FAIL rstmid_cs: got %b, required 11", spi_cs_n); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else n_pass++;
    @(negedge clk28); rst_n = 1'b1;
    m_cs = 2'b11; m_ovr = 1'b0; m_rx = 8'hFF;
    miso_pat = 8'h00; clear_mon();
    io_read(DATA, v, act);
    n_checks++; if (v !== m_rx) $display("FAIL rstmid_rx: got %h, required %h", v, m_rx); else n_pass++;
    wait_idle("rstmid", 300);
    n_checks++; if (busy_cnt != 17) $display("FAIL rstmid_div: got %0d, required 17", busy_cnt); else n_pass++;
    io_read(CTRL, v, act);
    n_checks++; if (v !== exp_status(1'b0)) $display("FAIL rstmid_status: got %h, required %h", v, exp_status(1'b0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div();
    test_collision();
    test_cs_mid();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
